memory_rstl_conv_pool: RTL and testbench
========================================

// Module: memory_rstl_conv_pool
// PURPOSE
//  Multi-channel conv-result frame buffer with a built-in 2x2/stride-2 max-pool read engine.
//  Sits between the conv layer (N_CH lanes written in parallel, raster order) and the dense/next layer.
//  Replaces per-layer single-channel result memories; pooled results leave over a valid/ready stream.
// PARAMETERS
//  N_C      26   feature-map columns
//  N_R      26   feature-map rows
//  N_CH     4    channels (parallel lanes, one RAM per lane)
//  DATA_W   8    signed pixel width
//  ADDR_W   10   RAM address width; must satisfy 2**ADDR_W >= N_R*N_C
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  wr_en      in   1              write one pixel per lane at internal write pointer
//  wr_data    in   N_CH*DATA_W    lane k = bits [k*DATA_W +: DATA_W], signed
//  frame_full out  1              N_R*N_C pixels stored; further writes ignored
//  start      in   1              one-cycle pulse: begin pooling the stored frame
//  busy       out  1              pool engine not IDLE
//  out_valid  out  1              pooled result available
//  out_ready  in   1              consumer accepts result when out_valid & out_ready
//  out_data   out  N_CH*DATA_W    per-lane signed max of the 2x2 window
//  out_row    out  ADDR_W         pooled row index, 0..N_R/2-1
//  out_col    out  ADDR_W         pooled col index, 0..N_C/2-1
//  done       out  1              one-cycle pulse after last pooled result is accepted
// BEHAVIOUR
//  Reset: wr_ptr=0, frame_full=0, state=IDLE, busy=0, out_valid=0, out_data=0, out_row=0, out_col=0, done=0.
//  Reset asserted mid-frame or mid-pool aborts; RAM contents undefined and not relied upon.
//  Write: wr_en & !frame_full & state==IDLE -> mem[k][wr_ptr]<=lane k; wr_ptr++.
//   When wr_ptr reaches N_R*N_C-1 and is written, frame_full<=1 the next cycle. Otherwise wr_en is dropped.
//  Start: honoured only when state==IDLE & frame_full; otherwise ignored (no error flag).
//  FSM: IDLE -> RD (cnt 0..3) -> LAST -> OUT -> (RD for next window | DONE) -> IDLE.
//   RD cnt issues read addr: 0:(2r)*N_C+2c, 1:+1, 2:+N_C, 3:+N_C+1. RAM read latency 1 cycle.
//   Data from cnt0 loads acc; later reads do acc<=max(acc,rdata), signed compare per lane.
//   LAST absorbs the 4th read and then enters OUT with out_valid=1.
//   out_valid is high 5 cycles after start is sampled (RD0..RD3, LAST).
//  OUT: out_data/out_row/out_col held stable while out_valid & !out_ready.
//   On handshake: col++. If col==N_C/2-1, col wraps to 0 and row++.
//   After the last window (row=N_R/2-1, col=N_C/2-1), go to DONE.
//   Otherwise go to RD; the next out_valid comes 5 cycles after the handshake.
//  DONE: done=1 for one cycle, frame_full<=0, wr_ptr<=0, -> IDLE. Buffer accepts the next frame on the next cycle.
//  Odd N_R/N_C: the last row/col is dropped (floor), matching valid-padding pooling.
//  Write pointer and read addresses: compute in ADDR_W bits. No wrap beyond N_R*N_C-1.
//  No combinational path from out_ready to out_valid or out_data.
// STRUCTURE
//  Package cnn_pkg: DATA_W default, pooled-dim function pool_dim(n)=n/2, FSM state enum localparams.
//  Sub-module rstl_ram_sp: one simple dual-port RAM (1W/1R, sync read, no reset) instantiated N_CH times via generate.
//  Top holds the write pointer, the FSM, per-lane max accumulators and output registers.
// TESTING
//  1. Write 676 pixels, lane0 = (i%128) signed, start -> first out_data lane0 = 27, row0/col0. 169 results, then done pulse.
//  2. Lane1 all = -5 except pixel (1,1) = -2 -> window(0,0) lane1 = -2; all other windows = -5 (checks signed max).
//  3. Hold out_ready=0 for 10 cycles on window 3 -> out_* stable, out_valid held. Release -> exactly one accept.
//  4. wr_en for 700 cycles -> frame_full after 676; extra writes leave RAM unchanged (verify pooled values).
//  5. start with frame_full=0, or start while busy -> ignored: busy and out_valid stay unchanged.
//  6. rst_n low during window 50 -> all outputs 0 asynchronously. Refill + start -> 169 correct results.
//  7. Bench param N_R=N_C=5, N_CH=2 -> 2x2 pooled outputs; row 4/col 4 ignored.

Source files
------------

// File: rtl/memory_rstl_conv_pool_pkg.sv
// Shared definitions for the conv-result frame buffer and its max-pool engine:
// default pixel width, pooled-dimension helper and the pool FSM state encoding.
package cnn_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAST = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } pool_state_e;

  // Valid-padding 2x2/stride-2 pooling: an odd trailing row/column is dropped.
  function automatic int pool_dim(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/rstl_ram_sp.sv
// One lane of the frame buffer: 1 write port, 1 read port, synchronous read
// with one cycle of latency, no reset on the storage or the read register.
module rstl_ram_sp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write the addressed word and register the read word every cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_rstl_conv_pool.sv
// Multi-channel conv-result frame buffer. The conv layer writes N_CH lanes in
// raster order; on start the engine walks every 2x2/stride-2 window, keeps a
// signed per-lane running max and streams each pooled pixel over valid/ready.
module memory_rstl_conv_pool
  import cnn_pkg::*;
#(
  parameter int N_C    = 26,
  parameter int N_R    = 26,
  parameter int N_CH   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [N_CH*DATA_W-1:0] wr_data,
  output logic                   frame_full,
  input  logic                   start,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]      out_row,
  output logic [ADDR_W-1:0]      out_col,
  output logic                   done
);

  localparam int              NPIX     = N_R * N_C;
  localparam int              PR       = pool_dim(N_R);
  localparam int              PC       = pool_dim(N_C);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(PR - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(PC - 1);
  localparam logic [ADDR_W-1:0] NC_A     = ADDR_W'(N_C);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  pool_state_e               state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic                      frame_full_q, frame_full_d;
  logic                      busy_q, busy_d;
  logic                      out_valid_q, out_valid_d;
  logic                      done_q, done_d;
  logic [ADDR_W-1:0]         row_q, row_d;
  logic [ADDR_W-1:0]         col_q, col_d;
  logic [N_CH*DATA_W-1:0]    acc_q, acc_d;
  logic [N_CH*DATA_W-1:0]    out_data_q, out_data_d;

  logic                      we_s;
  logic [ADDR_W-1:0]         row2_s, col2_s, base_s, raddr_s;
  logic [N_CH*DATA_W-1:0]    rdata_s, max_s;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    if ($signed(a) >= $signed(b)) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Writes are only taken while idle and until the frame is complete.
  assign we_s = wr_en & ~frame_full_q & (state_q == ST_IDLE);

  // Read address of the current window tap: top-left, top-right, bottom-left, bottom-right.
  always_comb begin
    row2_s = {row_q[ADDR_W-2:0], 1'b0};
    col2_s = {col_q[ADDR_W-2:0], 1'b0};
    base_s = (row2_s * NC_A) + col2_s;
    case (cnt_q)
      2'd0:    raddr_s = base_s;
      2'd1:    raddr_s = base_s + ONE_A;
      2'd2:    raddr_s = base_s + NC_A;
      2'd3:    raddr_s = base_s + NC_A + ONE_A;
      default: raddr_s = base_s;
    endcase
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    rstl_ram_sp #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk    (clk),
      .we_i   (we_s),
      .waddr_i(wr_ptr_q),
      .wdata_i(wr_data[k*DATA_W +: DATA_W]),
      .raddr_i(raddr_s),
      .rdata_o(rdata_s[k*DATA_W +: DATA_W])
    );
  end

  // Per-lane signed max of the running accumulator and the word just read.
  always_comb begin
    max_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      max_s[k*DATA_W +: DATA_W] = smax(acc_q[k*DATA_W +: DATA_W], rdata_s[k*DATA_W +: DATA_W]);
    end
  end

  // Next-state logic for the write pointer, the pool FSM and the output registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    frame_full_d = frame_full_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;
    row_d        = row_q;
    col_d        = col_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;

    // The pointer parks on the last address; frame_full blocks further writes.
    if (we_s) begin
      if (wr_ptr_q == LAST_PTR) begin
        frame_full_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + ONE_A;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && frame_full_q) begin
          state_d = ST_RD;
          cnt_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        // rdata_s carries the tap issued one cycle earlier.
        if (cnt_q == 2'd1) begin
          acc_d = rdata_s;
        end else if (cnt_q != 2'd0) begin
          acc_d = max_s;
        end else begin
          acc_d = acc_q;
        end
        if (cnt_q == 2'd3) begin
          state_d = ST_LAST;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_LAST: begin
        out_data_d  = max_s;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if ((row_q == LAST_ROW) && (col_q == LAST_COL)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = ST_RD;
            cnt_d   = 2'd0;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + ONE_A;
            end else begin
              col_d = col_q + ONE_A;
            end
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_DONE: begin
        frame_full_d = 1'b0;
        wr_ptr_d     = '0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any frame or pool in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      wr_ptr_q     <= '0;
      frame_full_q <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      frame_full_q <= frame_full_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      row_q        <= row_d;
      col_q        <= col_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
    end
  end

  assign frame_full = frame_full_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign done       = done_q;

endmodule

// File: tb/tb_memory_rstl_conv_pool.sv
// Directed bench for memory_rstl_conv_pool: a 26x26x4 instance and a 5x5x2 instance.
module tb_memory_rstl_conv_pool;

  localparam int NC   = 26;
  localparam int NR   = 26;
  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int NPIX = NR * NC;
  localparam int PC   = NC / 2;
  localparam int PR   = NR / 2;
  localparam int NWIN = PR * PC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [NCH*DW-1:0] wr_data = '0;
  logic [NCH*DW-1:0] out_data;
  logic frame_full, busy, out_valid, done;
  logic [AW-1:0] out_row, out_col;

  logic s_wr_en = 1'b0, s_start = 1'b0, s_out_ready = 1'b0;
  logic [2*DW-1:0] s_wr_data = '0;
  logic [2*DW-1:0] s_out_data;
  logic s_frame_full, s_busy, s_out_valid, s_done;
  logic [AW-1:0] s_out_row, s_out_col;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memory_rstl_conv_pool #(.N_C(NC), .N_R(NR), .N_CH(NCH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .frame_full(frame_full),
    .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .done(done)
  );

  memory_rstl_conv_pool #(.N_C(5), .N_R(5), .N_CH(2), .DATA_W(DW), .ADDR_W(AW)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_data(s_wr_data), .frame_full(s_frame_full),
    .start(s_start), .busy(s_busy), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_row(s_out_row), .out_col(s_out_col), .done(s_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pixel i of the test frame, lanes {3,2,1,0}.
  function automatic logic [31:0] pix(input int i);
    logic [7:0] l0, l1, l2, l3;
    l0 = 8'(i % 128);
    l1 = (i == 27) ? 8'hFE : 8'hFB;
    l2 = 8'(i * 37 + 11);
    l3 = 8'(200 - 3 * i);
    return {l3, l2, l1, l0};
  endfunction

  // Reference 2x2 signed max of window (r,c).
  function automatic logic [31:0] exp_win(input int r, input int c);
    int base, off;
    logic [31:0] res, p;
    logic signed [7:0] a, b;
    base = 2 * r * NC + 2 * c;
    res  = pix(base);
    for (int j = 1; j < 4; j++) begin
      off = (j == 1) ? 1 : ((j == 2) ? NC : NC + 1);
      p   = pix(base + off);
      for (int k = 0; k < 4; k++) begin
        a = res[k*8 +: 8];
        b = p[k*8 +: 8];
        if (b > a) res[k*8 +: 8] = b;
      end
    end
    return res;
  endfunction

  task automatic write_frame(input int n);
    for (int i = 0; i < n; i++) begin
      if (i == NPIX - 1) check("ff_before_last", 64'(frame_full), 64'd0);
      if (i == NPIX) check("ff_after_last", 64'(frame_full), 64'd1);
      wr_en   = 1'b1;
      wr_data = (i < NPIX) ? pix(i) : 32'h7F7F7F7F;
      step();
    end
    wr_en = 1'b0;
    step();
    check("frame_full", 64'(frame_full), 64'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!out_valid) check("valid_timeout", 64'd0, 64'd1);
  endtask

  // Start a pool and consume windows; returns with out_valid high at window stop_at.
  task automatic run_pool(input int stop_at);
    int lat, r, c;
    logic [31:0] ew;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int w = 0; w < NWIN; w++) begin
      wait_valid(lat);
      check("latency", 64'(lat), 64'd5);
      if (w == stop_at) return;
      r  = w / PC;
      c  = w % PC;
      ew = exp_win(r, c);
      check("out_row", 64'(out_row), 64'(r));
      check("out_col", 64'(out_col), 64'(c));
      check("out_data", 64'(out_data), 64'(ew));
      check("no_done", 64'(done), 64'd0);
      if (w == 0) begin
        check("win0_lane0", 64'(out_data[7:0]), 64'd27);
        check("win0_lane1", 64'(out_data[15:8]), 64'hFE);
      end
      if (w == 1) check("win1_lane1", 64'(out_data[15:8]), 64'hFB);
      if (w == 3) begin
        for (int h = 0; h < 10; h++) begin
          start = (h == 4);
          step();
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_busy", 64'(busy), 64'd1);
          check("hold_data", 64'(out_data), 64'(ew));
          check("hold_col", 64'(out_col), 64'(c));
        end
        start = 1'b0;
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (w == NWIN - 1) begin
        check("done", 64'(done), 64'd1);
        step();
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("ff_cleared", 64'(frame_full), 64'd0);
      end else begin
        check("one_accept", 64'(out_valid), 64'd0);
      end
    end
  endtask

  initial begin
    logic [15:0] s_exp [4];
    int lat;
    s_exp[0] = 16'h0006;
    s_exp[1] = 16'hFE08;
    s_exp[2] = 16'hF610;
    s_exp[3] = 16'hF412;

    // Reset state
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_row", 64'(out_row), 64'd0);
    check("rst_col", 64'(out_col), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ff", 64'(frame_full), 64'd0);
    #2 rst_n = 1'b1;
    step();

    // Start without a stored frame is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("nostart_busy", 64'(busy), 64'd0);
    check("nostart_valid", 64'(out_valid), 64'd0);

    // Over-long write burst, then full pool with backpressure and start-while-busy
    write_frame(700);
    run_pool(-1);

    // Reset in the middle of window 50
    write_frame(NPIX);
    run_pool(50);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_row", 64'(out_row), 64'd0);
    check("arst_col", 64'(out_col), 64'd0);
    check("arst_ff", 64'(frame_full), 64'd0);
    #2 rst_n = 1'b1;
    step();
    write_frame(NPIX);
    run_pool(-1);

    // 5x5, two lanes: lane0 = i, lane1 = -i; row 4 and col 4 never pooled
    for (int i = 0; i < 25; i++) begin
      s_wr_en   = 1'b1;
      s_wr_data = {8'(-i), 8'(i)};
      step();
    end
    s_wr_en = 1'b0;
    step();
    check("s_frame_full", 64'(s_frame_full), 64'd1);
    s_out_ready = 1'b1;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      lat = 0;
      while (!s_out_valid && lat < 20) begin
        step();
        lat++;
      end
      check("s_latency", 64'(lat), 64'd5);
      check("s_row", 64'(s_out_row), 64'(w / 2));
      check("s_col", 64'(s_out_col), 64'(w % 2));
      check("s_data", 64'(s_out_data), 64'(s_exp[w]));
      step();
    end
    check("s_done", 64'(s_done), 64'd1);
    step();
    check("s_idle", 64'(s_busy), 64'd0);
    check("s_ff_cleared", 64'(s_frame_full), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
